// File: rtl/rv32_pkg.sv
// Shared RV32I types for the write-back path.
// Contents: register data/index widths, write-back source enum, load-queue entry struct.
package rv32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD
    } wb_src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_load_fifo.sv
// Synchronous FIFO of write-back entries holding load results waiting for the write port.
// Ports: clk, rst_n (async active-low), push/wdata (enqueue), pop (dequeue head),
//        rdata (current head), full, empty.
// Pointers carry one extra wrap bit: equal pointers mean empty, equal index with
// differing wrap bit means full.
module rf_wb_load_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t wdata,
    input  logic      pop,
    output wb_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer update; wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: empty pointers make contents irrelevant.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IDX_W-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[IDX_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

endmodule

// File: rtl/rf_writeback.sv
// Write-back unit owning the register-file write port. Merges ALU results (priority,
// no backpressure) with load results buffered in a small queue, and keeps a busy
// scoreboard of registers with outstanding loads for decode RAW stalls.
// Ports: clk, rst_n (async active-low); alu_valid/alu_rd/alu_data; ld_valid/ld_ready/
//        ld_rd/ld_data; issue_ld_valid/issue_ld_rd; rs1/rs2 -> rs1_hazard/rs2_hazard;
//        reg_write/write_reg/write_data (registered write port).
// Option RF_WB_BYPASS_EN: adds rsN_fwd_valid/rsN_fwd_data forwarding from the write
//        port and suppresses the hazard while forwarding.
module rf_writeback #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              issue_ld_valid,
    input  logic [ADDR_W-1:0] issue_ld_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_hazard,
    output logic              rs2_hazard,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data
`ifdef RF_WB_BYPASS_EN
    ,
    output logic              rs1_fwd_valid,
    output logic              rs2_fwd_valid,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic [DATA_W-1:0] rs2_fwd_data
`endif
);

    import rv32_pkg::*;

    localparam int unsigned NREG = 1 << ADDR_W;

    logic            q_full;
    logic            q_empty;
    logic            q_push;
    logic            q_pop;
    wb_entry_t       q_head;
    wb_entry_t       ld_entry;
    logic            ld_keep;
    logic            alu_sel;
    logic            direct_sel;
    wb_src_e         wb_src;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Selection: ALU first, then queue head, then a load straight through an empty queue.
    always_comb begin
        ld_entry      = '0;
        ld_entry.rd   = ld_rd;
        ld_entry.data = ld_data;
        ld_keep       = ld_valid && ld_ready && (ld_rd != '0);
        alu_sel       = alu_valid && (alu_rd != '0);
        direct_sel    = !alu_sel && q_empty && ld_keep;
        q_pop         = !alu_sel && !q_empty;
        q_push        = ld_keep && !direct_sel;
    end

    assign ld_ready = !q_full;

    rf_wb_load_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .wdata (ld_entry),
        .pop   (q_pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Write port register; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            wb_src     <= WB_NONE;
        end else if (alu_sel) begin
            reg_write  <= 1'b1;
            write_reg  <= alu_rd;
            write_data <= alu_data;
            wb_src     <= WB_ALU;
        end else if (!q_empty) begin
            reg_write  <= 1'b1;
            write_reg  <= q_head.rd;
            write_data <= q_head.data;
            wb_src     <= WB_LOAD;
        end else if (direct_sel) begin
            reg_write  <= 1'b1;
            write_reg  <= ld_rd;
            write_data <= ld_data;
            wb_src     <= WB_LOAD;
        end else begin
            reg_write  <= 1'b0;
            wb_src     <= WB_NONE;
        end
    end

    // Scoreboard: clear on a load write leaving the port, then set on issue (set wins).
    always_comb begin
        busy_next = busy;
        if (reg_write && (wb_src == WB_LOAD)) busy_next[write_reg] = 1'b0;
        if (issue_ld_valid) busy_next[issue_ld_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd_valid = reg_write && (write_reg == rs1) && (rs1 != '0);
    assign rs2_fwd_valid = reg_write && (write_reg == rs2) && (rs2 != '0);
    assign rs1_fwd_data  = write_data;
    assign rs2_fwd_data  = write_data;
    assign rs1_hazard    = busy[rs1] && (rs1 != '0) && !rs1_fwd_valid;
    assign rs2_hazard    = busy[rs2] && (rs2 != '0) && !rs2_fwd_valid;
`else
    assign rs1_hazard    = busy[rs1] && (rs1 != '0);
    assign rs2_hazard    = busy[rs2] && (rs2 != '0);
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed vector table, hand-written
// scoreboard/reset sequences, and randomized traffic against a queue-based model.
module tb_rf_writeback;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned LQ = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          issue_ld_valid;
    logic [AW-1:0] issue_ld_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1_hazard;
    logic          rs2_hazard;
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
`ifdef RF_WB_BYPASS_EN
    logic          rs1_fwd_valid;
    logic          rs2_fwd_valid;
    logic [DW-1:0] rs1_fwd_data;
    logic [DW-1:0] rs2_fwd_data;
`endif

    always #5 clk = ~clk;

    rf_writeback #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .LQ_DEPTH (LQ)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .issue_ld_valid (issue_ld_valid),
        .issue_ld_rd    (issue_ld_rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .rs1_hazard     (rs1_hazard),
        .rs2_hazard     (rs2_hazard),
        .reg_write      (reg_write),
        .write_reg      (write_reg),
        .write_data     (write_data)
`ifdef RF_WB_BYPASS_EN
        ,
        .rs1_fwd_valid  (rs1_fwd_valid),
        .rs2_fwd_valid  (rs2_fwd_valid),
        .rs1_fwd_data   (rs1_fwd_data),
        .rs2_fwd_data   (rs2_fwd_data)
`endif
    );

    // Reference model: pending loads as a queue, busy set as a bit array.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    bit            m_busy[32];
    bit            m_rw;
    bit            m_src_load;
    logic [AW-1:0] m_wreg;
    logic [DW-1:0] m_wdata;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fwd(input logic [AW-1:0] rs);
        return m_rw && (m_wreg == rs) && (rs != 0);
    endfunction

    function automatic bit m_haz(input logic [AW-1:0] rs);
        bit h;
        h = m_busy[rs] && (rs != 0);
`ifdef RF_WB_BYPASS_EN
        if (m_fwd(rs)) h = 1'b0;
`endif
        return h;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_rw       = 1'b0;
        m_src_load = 1'b0;
        m_wreg     = '0;
        m_wdata    = '0;
    endtask

    task automatic check_all();
        chk("ld_ready", 32'(ld_ready), 32'(mq.size() < LQ));
        chk("rs1_hazard", 32'(rs1_hazard), 32'(m_haz(rs1)));
        chk("rs2_hazard", 32'(rs2_hazard), 32'(m_haz(rs2)));
        chk("reg_write", 32'(reg_write), 32'(m_rw));
        chk("write_reg", 32'(write_reg), 32'(m_wreg));
        chk("write_data", write_data, m_wdata);
`ifdef RF_WB_BYPASS_EN
        chk("rs1_fwd_valid", 32'(rs1_fwd_valid), 32'(m_fwd(rs1)));
        chk("rs2_fwd_valid", 32'(rs2_fwd_valid), 32'(m_fwd(rs2)));
        chk("rs1_fwd_data", rs1_fwd_data, m_wdata);
        chk("rs2_fwd_data", rs2_fwd_data, m_wdata);
`endif
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit   keep;
        ent_t e;
        keep = ld_valid && (mq.size() < LQ) && (ld_rd != 0);
        if (m_rw && m_src_load) m_busy[m_wreg] = 1'b0;
        if (issue_ld_valid) m_busy[issue_ld_rd] = 1'b1;
        m_busy[0] = 1'b0;
        e.rd   = ld_rd;
        e.data = ld_data;
        if (alu_valid && alu_rd != 0) begin
            m_rw = 1'b1; m_src_load = 1'b0; m_wreg = alu_rd; m_wdata = alu_data;
            if (keep) mq.push_back(e);
        end else if (mq.size() > 0) begin
            ent_t h;
            h = mq.pop_front();
            m_rw = 1'b1; m_src_load = 1'b1; m_wreg = h.rd; m_wdata = h.data;
            if (keep) mq.push_back(e);
        end else if (keep) begin
            m_rw = 1'b1; m_src_load = 1'b1; m_wreg = ld_rd; m_wdata = ld_data;
        end else begin
            m_rw = 1'b0; m_src_load = 1'b0;
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_valid = 0; ld_rd = '0; ld_data = '0;
        issue_ld_valid = 0; issue_ld_rd = '0;
        rs1 = '0; rs2 = '0;
    endtask

    typedef struct {
        bit            av;
        logic [AW-1:0] ard;
        logic [DW-1:0] adat;
        bit            lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ldat;
        bit            exp_ready;
        bit            exp_rw;
        logic [AW-1:0] exp_wr;
        logic [DW-1:0] exp_wd;
    } vec_t;

    vec_t vt[9];

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_reg_write", 32'(reg_write), 0);
        chk("rst_write_reg", 32'(write_reg), 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_rs1_hazard", 32'(rs1_hazard), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU path, then contention: 4 ALU writes while loads rd7/rd8 queue up.
        vt[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 1, 5'd5, 32'hDEADBEEF};
        vt[1] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 0, 5'd5, 32'hDEADBEEF};
        vt[2] = '{1, 5'd1, 32'hA0,       1, 5'd7, 32'h11, 1, 1, 5'd1, 32'hA0};
        vt[3] = '{1, 5'd2, 32'hA1,       1, 5'd8, 32'h22, 1, 1, 5'd2, 32'hA1};
        vt[4] = '{1, 5'd3, 32'hA2,       1, 5'd9, 32'h33, 0, 1, 5'd3, 32'hA2};
        vt[5] = '{1, 5'd4, 32'hA3,       0, 5'd0, 32'h0,  0, 1, 5'd4, 32'hA3};
        vt[6] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 1, 5'd7, 32'h11};
        vt[7] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1, 5'd8, 32'h22};
        vt[8] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 0, 5'd8, 32'h22};
        for (int i = 0; i < 9; i++) begin
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].adat;
            ld_valid  = vt[i].lv; ld_rd  = vt[i].lrd; ld_data  = vt[i].ldat;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(ld_ready), 32'(vt[i].exp_ready));
            tick();
            chk($sformatf("vec%0d_rw", i), 32'(reg_write), 32'(vt[i].exp_rw));
            chk($sformatf("vec%0d_wreg", i), 32'(write_reg), 32'(vt[i].exp_wr));
            chk($sformatf("vec%0d_wdata", i), write_data, vt[i].exp_wd);
        end
        idle_inputs();

        // Scoreboard: issue rd10, load returns on an idle port.
        issue_ld_valid = 1; issue_ld_rd = 5'd10; rs1 = 5'd10;
        tick();
        issue_ld_valid = 0;
        #1 chk("sb_set_haz", 32'(rs1_hazard), 1);
        ld_valid = 1; ld_rd = 5'd10; ld_data = 32'h1234;
        tick();
        ld_valid = 0;
        #1;
        chk("sb_wr_rw", 32'(reg_write), 1);
        chk("sb_wr_reg", 32'(write_reg), 10);
        chk("sb_wr_data", write_data, 32'h1234);
`ifdef RF_WB_BYPASS_EN
        chk("sb_fwd_valid", 32'(rs1_fwd_valid), 1);
        chk("sb_fwd_data", rs1_fwd_data, 32'h1234);
        chk("sb_wr_haz", 32'(rs1_hazard), 0);
`else
        chk("sb_wr_haz", 32'(rs1_hazard), 1);
`endif
        tick();
        #1 chk("sb_clr_haz", 32'(rs1_hazard), 0);

        // Re-issue of rd3 on the same edge its load write clears it: stays busy.
        issue_ld_valid = 1; issue_ld_rd = 5'd3; rs1 = 5'd3;
        tick();
        issue_ld_valid = 0;
        ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h55;
        tick();
        ld_valid = 0;
        issue_ld_valid = 1; issue_ld_rd = 5'd3;
        tick();
        issue_ld_valid = 0;
        #1 chk("setclr_haz", 32'(rs1_hazard), 1);
        ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h66;
        tick();
        ld_valid = 0;
        tick();
        tick();
        #1 chk("setclr_final_haz", 32'(rs1_hazard), 0);

        // x0 everywhere: nothing written, no hazard.
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        ld_valid = 1; ld_rd = 5'd0; ld_data = 32'hEEEE;
        issue_ld_valid = 1; issue_ld_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("x0_rw", 32'(reg_write), 0);
            chk("x0_haz1", 32'(rs1_hazard), 0);
            chk("x0_haz2", 32'(rs2_hazard), 0);
        end
        idle_inputs();
        tick();

        // Mid-operation reset with two queued loads and a busy register.
        issue_ld_valid = 1; issue_ld_rd = 5'd12; rs1 = 5'd12;
        tick();
        issue_ld_valid = 0;
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hC1;
        ld_valid = 1; ld_rd = 5'd12; ld_data = 32'h77;
        tick();
        alu_rd = 5'd2; alu_data = 32'hC2; ld_rd = 5'd13; ld_data = 32'h88;
        tick();
        ld_valid = 0; alu_rd = 5'd3; alu_data = 32'hC3;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rw", 32'(reg_write), 0);
        chk("mid_rst_ready", 32'(ld_ready), 1);
        chk("mid_rst_wreg", 32'(write_reg), 0);
        chk("mid_rst_wdata", write_data, 0);
        chk("mid_rst_haz", 32'(rs1_hazard), 0);
        model_reset();
        idle_inputs();
        rs1 = 5'd12;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_rw", 32'(reg_write), 0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            alu_valid      = ($urandom_range(0, 99) < 40);
            alu_rd         = AW'($urandom_range(0, 7));
            alu_data       = $urandom;
            ld_valid       = ($urandom_range(0, 99) < 50);
            ld_rd          = AW'($urandom_range(0, 7));
            ld_data        = $urandom;
            issue_ld_valid = ($urandom_range(0, 99) < 30);
            issue_ld_rd    = AW'($urandom_range(0, 7));
            rs1            = AW'($urandom_range(0, 7));
            rs2            = AW'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
